// File: rtl/serializer_pkg.sv
// Shared types and helpers for the serial-link transmitter.
package serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits needed to index 0..value-1.
    function automatic int log2_ceil(input int value);
        return $clog2(value);
    endfunction

endpackage

// File: rtl/serializer_strobe_gen.sv
// Bit-strobe generator: free-running divide-by-CLK_DIV counter, strobe on count zero.
module strobe_gen
    import serializer_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic strobe
);

    localparam int CNT_W = log2_ceil(CLK_DIV) + 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at CLK_DIV-1 while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = CNT_W'(0);
        end else if (run) begin
            if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                cnt_d = CNT_W'(0);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_W'(0);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe = run && (cnt_q == CNT_W'(0));

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: one-word holding buffer feeding an MSB-first shifter.
module serializer
    import serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  serial_out,
    output logic                  start_out,
    output logic                  enable_out,
    output logic                  busy,
    output logic                  done
);

    localparam int BIT_W = log2_ceil(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  serial_q, serial_d;
    logic                  start_q, start_d;
    logic                  enable_q, enable_d;
    logic                  last_q, last_d;
    logic                  done_q;

    logic accept;
    logic strobe;
    logic div_clear;
    logic div_run;

    assign accept    = in_valid && in_ready_q;
    assign div_clear = (state_q == ST_IDLE);
    assign div_run   = (state_q == ST_SHIFT);

    // The divider keeps running across a gapless reload so packet spacing matches bit spacing.
    strobe_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (div_clear),
        .run    (div_run),
        .strobe (strobe)
    );

    // Next-state: buffer fill, FSM, shifter and registered line outputs.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_idx_d    = bit_idx_q;
        serial_d     = serial_q;
        start_d      = 1'b0;
        enable_d     = 1'b0;
        last_d       = 1'b0;

        if (accept) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
        end else begin
            hold_d       = hold_q;
        end

        case (state_q)
            ST_IDLE: begin
                serial_d = 1'b0;
                if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    bit_idx_d    = BIT_W'(0);
                    state_d      = ST_SHIFT;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (strobe) begin
                    enable_d = 1'b1;
                    start_d  = (bit_idx_q == BIT_W'(0));
                    serial_d = shift_q[DATA_WIDTH-1];
                    shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    if (bit_idx_q == BIT_W'(DATA_WIDTH - 1)) begin
                        last_d    = 1'b1;
                        bit_idx_d = BIT_W'(0);
                        if (hold_valid_q) begin
                            shift_d      = hold_q;
                            hold_valid_d = 1'b0;
                        end else begin
                            state_d      = ST_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                    end
                end else begin
                    serial_d = serial_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = !hold_valid_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            bit_idx_q    <= BIT_W'(0);
            serial_q     <= 1'b0;
            start_q      <= 1'b0;
            enable_q     <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            in_ready_q   <= in_ready_d;
            bit_idx_q    <= bit_idx_d;
            serial_q     <= serial_d;
            start_q      <= start_d;
            enable_q     <= enable_d;
            last_q       <= last_d;
            done_q       <= last_q;
        end
    end

    assign in_ready   = in_ready_q;
    assign serial_out = serial_q;
    assign start_out  = start_q;
    assign enable_out = enable_q;
    assign busy       = (state_q == ST_SHIFT);
    assign done       = done_q;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: three instances (CLK_DIV 1, 3, 4), each watched by a receiver model.
module tb_serializer;

    localparam int NI = 3;

    function automatic int cd_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    endfunction

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    in_data [NI];
    logic [NI-1:0] in_valid;
    logic [NI-1:0] in_ready;
    logic [NI-1:0] ser;
    logic [NI-1:0] start;
    logic [NI-1:0] en;
    logic [NI-1:0] busy;
    logic [NI-1:0] done;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q [NI][$];
    int         rx_cnt  [NI] = '{default: 0};
    int         acc_cnt [NI] = '{default: 0};

    always #5 clk = ~clk;

    task automatic check(input int g, input string tag, input logic [31:0] obs, input logic [31:0] expd);
        vectors++;
        assert (obs === expd) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, g, obs, expd);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CD = cd_of(g);

        serializer #(.DATA_WIDTH(8), .CLK_DIV(CD)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_data    (in_data[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .serial_out (ser[g]),
            .start_out  (start[g]),
            .enable_out (en[g]),
            .busy       (busy[g]),
            .done       (done[g])
        );

        // Words handed over on accepting edges, in order.
        always @(posedge clk) begin
            if (!rst && in_valid[g] && in_ready[g]) begin
                exp_q[g].push_back(in_data[g]);
                acc_cnt[g]++;
            end
        end

        // Receiver model: collects bits on strobes, checks framing, spacing and done timing.
        int         nbits    = 0;
        int         since    = 0;
        logic [7:0] sh       = 8'h00;
        logic       prev_ser = 1'b0;
        logic       done_due = 1'b0;
        logic       seen     = 1'b0;

        always @(negedge clk) begin
            if (rst) begin
                nbits    = 0;
                since    = 0;
                done_due = 1'b0;
                seen     = 1'b0;
                exp_q[g].delete();
            end else begin
                check(g, "done", 32'(done[g]), 32'(done_due));
                done_due = 1'b0;
                since++;
                if (en[g]) begin
                    check(g, "start", 32'(start[g]), 32'(nbits == 0));
                    if (seen && nbits != 0) check(g, "spacing", 32'(since), 32'(CD));
                    if (seen && nbits == 0) check(g, "pkt_gap", 32'(since >= CD), 32'd1);
                    if (nbits < 7) check(g, "busy_strobe", 32'(busy[g]), 32'd1);
                    sh       = {sh[6:0], ser[g]};
                    prev_ser = ser[g];
                    seen     = 1'b1;
                    since    = 0;
                    nbits++;
                    if (nbits == 8) begin
                        if (exp_q[g].size() == 0) check(g, "rx_unexpected", 32'(sh), 32'hFFFF_FFFF);
                        else check(g, "rx_word", 32'(sh), 32'(exp_q[g].pop_front()));
                        rx_cnt[g]++;
                        nbits    = 0;
                        done_due = 1'b1;
                    end
                end else begin
                    check(g, "start_off", 32'(start[g]), 32'd0);
                    if (nbits != 0) begin
                        check(g, "hold", 32'(ser[g]), 32'(prev_ser));
                        check(g, "busy_mid", 32'(busy[g]), 32'd1);
                    end
                end
            end
        end
    end

    task automatic send(input int g, input logic [7:0] w);
        int n;
        @(negedge clk);
        in_data[g]  = w;
        in_valid[g] = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!in_ready[g] && n < 50);
        check(g, "accept", 32'(in_ready[g]), 32'd1);
        #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic tx_check(input int g, input logic [7:0] w, input int cd);
        int cyc;
        send(g, w);
        for (int n = 0; n < 8; n++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!en[g] && cyc < 64);
            if (n == 0) check(g, "latency", 32'(cyc), 32'd3);
            else check(g, "strobe_period", 32'(cyc), 32'(cd));
            check(g, "bit", 32'(ser[g]), 32'(w[7-n]));
            check(g, "start_dir", 32'(start[g]), 32'(n == 0));
        end
        @(negedge clk);
        check(g, "done_dir", 32'(done[g]), 32'd1);
        check(g, "busy_after", 32'(busy[g]), 32'd0);
    endtask

    task automatic check_reset_outputs(input int g);
        check(g, "rst_serial", 32'(ser[g]), 32'd0);
        check(g, "rst_start", 32'(start[g]), 32'd0);
        check(g, "rst_enable", 32'(en[g]), 32'd0);
        check(g, "rst_busy", 32'(busy[g]), 32'd0);
        check(g, "rst_done", 32'(done[g]), 32'd0);
        check(g, "rst_ready", 32'(in_ready[g]), 32'd1);
    endtask

    initial begin
        int n;
        int cyc;
        int dn;
        int acc0 [2];
        int rx0  [2];

        in_valid = '0;
        for (int g = 0; g < NI; g++) in_data[g] = 8'h00;

        // Power-on reset.
        #1 rst = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) check_reset_outputs(g);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Single word, one bit per clock, then a slow divider.
        tx_check(0, 8'hA5, 1);
        tx_check(2, 8'h81, 4);

        // Back-to-back: 16 gapless strobes, two done pulses.
        send(0, 8'hFF);
        @(negedge clk);
        check(0, "b2b_full", 32'(in_ready[0]), 32'd0);
        send(0, 8'h00);
        dn = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i < 16) begin
                check(0, "b2b_enable", 32'(en[0]), 32'd1);
                check(0, "b2b_start", 32'(start[0]), 32'(i == 0 || i == 8));
                check(0, "b2b_ready", 32'(in_ready[0]), 32'(i >= 7));
            end
            if (done[0]) dn++;
        end
        check(0, "b2b_done_cnt", 32'(dn), 32'd2);

        // Reset mid-packet, away from any clock edge.
        send(0, 8'hC3);
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (en[0]) n++;
        end
        check(0, "pre_rst_strobes", 32'(n), 32'd3);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs(0);
        @(negedge clk);
        #2 rst = 1'b0;
        tx_check(0, 8'h3C, 1);

        // Random traffic with backpressure on the CLK_DIV=1 and CLK_DIV=3 instances.
        for (int g = 0; g < 2; g++) begin
            acc0[g] = acc_cnt[g];
            rx0[g]  = rx_cnt[g];
        end
        cyc = 0;
        while ((acc_cnt[0] - acc0[0] < 100 || acc_cnt[1] - acc0[1] < 100) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < 2; g++) begin
                in_data[g]  = 8'($urandom);
                in_valid[g] = (acc_cnt[g] - acc0[g] < 100) && ($urandom_range(0, 3) != 0);
            end
        end
        in_valid = '0;
        cyc = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (4) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check(g, "rand_accepted", 32'(acc_cnt[g] - acc0[g]), 32'd100);
            check(g, "rand_received", 32'(rx_cnt[g] - rx0[g]), 32'd100);
            check(g, "rand_drained", 32'(exp_q[g].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
